bpb_resolver: RTL and testbench

//  Resolution end of the branch predictor buffer: queues each prediction made at fetch, checks it
//  in order against the real outcome at execute, and raises mispredict + redirect address.

---
 rtl/bpb_pkg.sv | 16 +
 rtl/bpb_pred_fifo.sv | 75 +++++++
 rtl/bpb_resolver.sv | 108 ++++++++++
 tb/tb_bpb_resolver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpb_pkg.sv
// Shared types and constants for the branch predictor buffer resolution logic.
//   bpb_entry_t       : one queued prediction (fetch pc, predicted direction, predicted target)
//   BPB_DELAY_OFFSET  : fall-through distance past a branch and its delay slot
//   BPB_DEFAULT_DEPTH : default prediction queue depth
package bpb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] addr;
  } bpb_entry_t;

  localparam logic [31:0] BPB_DELAY_OFFSET  = 32'd8;
  localparam int unsigned BPB_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/bpb_pred_fifo.sv
// Circular prediction queue, DEPTH entries of bpb_entry_t.
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-low reset
//   push_i, wdata_i   enqueue one entry (ignored while full)
//   pop_i             dequeue the head entry (ignored while empty)
//   clear_i           empty the queue at the edge; overrides push
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
module bpb_pred_fifo
  import bpb_pkg::*;
#(
  parameter int unsigned DEPTH = BPB_DEFAULT_DEPTH,
  parameter int unsigned PTR_W = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  bpb_entry_t wdata_i,
  output bpb_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  bpb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_eff, pop_eff;

  assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;
  assign rdata_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_eff && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bpb_resolver.sv
// Resolution end of the branch predictor buffer. Queues every fetch-time prediction, checks the
// oldest one against the execute-stage outcome, flags mispredicts with the correct redirect
// address, drives a registered training port and keeps saturating hit/miss counters.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   stall_i, flush_i                 freeze all state / empty the queue
//   pred_*_i, pred_ready_o           prediction push from IF
//   res_*_i                          resolution of the oldest prediction from EX
//   mispredict_o, redirect_addr_o    combinational front-end redirect
//   upd_*_o                          registered BPB training write
//   hit_cnt_o, miss_cnt_o            statistics
//   empty_o, proto_err_o             queue empty, sticky resolve-on-empty error
module bpb_resolver
  import bpb_pkg::*;
#(
  parameter int unsigned DEPTH = BPB_DEFAULT_DEPTH,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_addr_i,
  output logic             pred_ready_o,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_addr_i,
  output logic             mispredict_o,
  output logic [31:0]      redirect_addr_o,
  output logic             upd_valid_o,
  output logic [31:0]      upd_pc_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_addr_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             empty_o,
  output logic             proto_err_o
);

  bpb_entry_t head, wdata;
  logic       fifo_full, fifo_empty;
  logic       push, pop, miss, clear;

  assign wdata = '{pc: pred_pc_i, taken: pred_taken_i, addr: pred_addr_i};

  assign pred_ready_o = ~fifo_full;
  assign empty_o      = fifo_empty;

  assign pop  = res_valid_i & ~fifo_empty & ~stall_i;
  assign miss = (head.taken != res_taken_i) | (res_taken_i & (head.addr != res_addr_i));

  assign mispredict_o = pop & miss;
  always_comb begin
    redirect_addr_o = '0;
    if (mispredict_o) begin
      redirect_addr_o = res_taken_i ? res_addr_i : head.pc + BPB_DELAY_OFFSET;
    end
  end

  // Younger entries behind a mispredict are wrong-path, so the queue is cleared as on a flush.
  assign push  = pred_valid_i & pred_ready_o & ~stall_i & ~flush_i & ~mispredict_o;
  assign clear = ~stall_i & (flush_i | mispredict_o);

  bpb_pred_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_valid_o <= 1'b0;
      upd_pc_o    <= '0;
      upd_taken_o <= 1'b0;
      upd_addr_o  <= '0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      proto_err_o <= 1'b0;
    end else begin
      upd_valid_o <= pop;
      if (pop) begin
        upd_pc_o    <= head.pc;
        upd_taken_o <= res_taken_i;
        upd_addr_o  <= res_addr_i;
        if (miss) begin
          if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
        end else begin
          if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
        end
      end
      if (res_valid_i && fifo_empty && !stall_i) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpb_resolver.sv
module tb_bpb_resolver;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i;
  logic        pred_valid_i, pred_taken_i;
  logic [31:0] pred_pc_i, pred_addr_i;
  logic        pred_ready_o;
  logic        res_valid_i, res_taken_i;
  logic [31:0] res_addr_i;
  logic        mispredict_o;
  logic [31:0] redirect_addr_o;
  logic        upd_valid_o, upd_taken_o;
  logic [31:0] upd_pc_o, upd_addr_o;
  logic [31:0] hit_cnt_o, miss_cnt_o;
  logic        empty_o, proto_err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];

  bpb_resolver #(
    .DEPTH (4),
    .PTR_W (2),
    .CNT_W (32)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .pred_valid_i    (pred_valid_i),
    .pred_pc_i       (pred_pc_i),
    .pred_taken_i    (pred_taken_i),
    .pred_addr_i     (pred_addr_i),
    .pred_ready_o    (pred_ready_o),
    .res_valid_i     (res_valid_i),
    .res_taken_i     (res_taken_i),
    .res_addr_i      (res_addr_i),
    .mispredict_o    (mispredict_o),
    .redirect_addr_o (redirect_addr_o),
    .upd_valid_o     (upd_valid_o),
    .upd_pc_o        (upd_pc_o),
    .upd_taken_o     (upd_taken_o),
    .upd_addr_o      (upd_addr_o),
    .hit_cnt_o       (hit_cnt_o),
    .miss_cnt_o      (miss_cnt_o),
    .empty_o         (empty_o),
    .proto_err_o     (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    stall_i = 0; flush_i = 0;
    pred_valid_i = 0; pred_pc_i = 0; pred_taken_i = 0; pred_addr_i = 0;
    res_valid_i = 0; res_taken_i = 0; res_addr_i = 0;
  endtask

  task automatic push_in(input logic [31:0] pc, input logic tk, input logic [31:0] ad);
    pred_valid_i = 1; pred_pc_i = pc; pred_taken_i = tk; pred_addr_i = ad;
  endtask

  task automatic res_in(input logic tk, input logic [31:0] ad);
    res_valid_i = 1; res_taken_i = tk; res_addr_i = ad;
  endtask

  // One cycle of in-order traffic; every resolution is correct (taken, target pc+0x40).
  task automatic cyc(input bit do_push, input logic [31:0] ppc, input bit do_pop);
    logic [31:0] head;
    bit          accept;
    accept = do_push && (mq.size() < 4);
    head   = do_pop ? mq[0] : 32'h0;
    idle_in();
    if (do_push) push_in(ppc, 1'b1, ppc + 32'h40);
    if (do_pop) res_in(1'b1, head + 32'h40);
    #1;
    if (do_pop) chk("fill_no_mispredict", mispredict_o, 0);
    tick();
    if (do_pop) begin
      void'(mq.pop_front());
      chk("fill_upd_valid", upd_valid_o, 1);
      chk("fill_upd_pc", upd_pc_o, head);
    end else begin
      chk("fill_upd_idle", upd_valid_o, 0);
    end
    if (accept) mq.push_back(ppc);
    chk("fill_ready", pred_ready_o, mq.size() < 4);
    chk("fill_empty", empty_o, mq.size() == 0);
  endtask

  initial begin
    idle_in();
    rst_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", pred_ready_o, 1);
    chk("rst_mispredict", mispredict_o, 0);
    chk("rst_redirect", redirect_addr_o, 0);
    chk("rst_upd_valid", upd_valid_o, 0);
    chk("rst_hit", hit_cnt_o, 0);
    chk("rst_miss", miss_cnt_o, 0);
    chk("rst_proto", proto_err_o, 0);
    rst_i = 1;
    tick();

    // Correct taken prediction
    push_in(32'h100, 1, 32'h200);
    tick();
    chk("a_not_empty", empty_o, 0);
    idle_in();
    res_in(1, 32'h200);
    #1;
    chk("a_mispredict", mispredict_o, 0);
    chk("a_redirect", redirect_addr_o, 0);
    tick();
    chk("a_upd_valid", upd_valid_o, 1);
    chk("a_upd_pc", upd_pc_o, 32'h100);
    chk("a_upd_taken", upd_taken_o, 1);
    chk("a_upd_addr", upd_addr_o, 32'h200);
    chk("a_hit", hit_cnt_o, 1);
    chk("a_empty", empty_o, 1);
    idle_in();
    tick();
    chk("a_upd_drop", upd_valid_o, 0);

    // Direction mispredict flushes younger entries and drops the same-cycle push
    push_in(32'h100, 0, 32'h0);
    tick();
    push_in(32'h104, 0, 32'h0);
    tick();
    push_in(32'h108, 0, 32'h0);
    tick();
    push_in(32'h10C, 0, 32'h0);
    res_in(1, 32'h300);
    #1;
    chk("b_mispredict", mispredict_o, 1);
    chk("b_redirect", redirect_addr_o, 32'h300);
    tick();
    chk("b_miss", miss_cnt_o, 1);
    chk("b_empty", empty_o, 1);
    chk("b_upd_pc", upd_pc_o, 32'h100);
    chk("b_upd_taken", upd_taken_o, 1);
    chk("b_upd_addr", upd_addr_o, 32'h300);
    idle_in();

    // Predicted taken, actually not taken: fall through past the delay slot
    push_in(32'h40, 1, 32'h80);
    tick();
    idle_in();
    res_in(0, 32'h0);
    #1;
    chk("c_mispredict", mispredict_o, 1);
    chk("c_redirect", redirect_addr_o, 32'h48);
    tick();
    chk("c_miss", miss_cnt_o, 2);
    chk("c_empty", empty_o, 1);

    // Right direction, wrong target
    idle_in();
    push_in(32'h180, 1, 32'h200);
    tick();
    idle_in();
    res_in(1, 32'h204);
    #1;
    chk("d_mispredict", mispredict_o, 1);
    chk("d_redirect", redirect_addr_o, 32'h204);
    tick();
    chk("d_miss", miss_cnt_o, 3);
    chk("d_hit", hit_cnt_o, 1);
    idle_in();
    tick();

    // Fill, drop when full, push+pop together, wrap pointers over 10 entries
    for (int i = 0; i < 4; i++) cyc(1, 32'h1000 + 32'(i * 4), 0);
    cyc(1, 32'h2000, 0);
    cyc(0, 32'h0, 1);
    cyc(1, 32'h1010, 1);
    cyc(1, 32'h1014, 0);
    for (int k = 6; k < 10; k++) begin
      cyc(0, 32'h0, 1);
      cyc(1, 32'h1000 + 32'(k * 4), 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1);
    chk("fill_hits", hit_cnt_o, 11);
    idle_in();
    tick();

    // Resolve with empty queue
    res_in(1, 32'h0);
    tick();
    chk("p_proto", proto_err_o, 1);
    chk("p_upd_valid", upd_valid_o, 0);
    chk("p_hit", hit_cnt_o, 11);
    chk("p_miss", miss_cnt_o, 3);
    idle_in();
    tick();
    chk("p_sticky", proto_err_o, 1);

    // Stall blocks resolution and mispredict
    push_in(32'h500, 1, 32'h600);
    tick();
    idle_in();
    stall_i = 1;
    res_in(0, 32'h0);
    #1;
    chk("s_mispredict", mispredict_o, 0);
    tick();
    chk("s_upd_valid", upd_valid_o, 0);
    chk("s_not_empty", empty_o, 0);
    chk("s_miss", miss_cnt_o, 3);
    stall_i = 0;
    #1;
    chk("s_release_mispredict", mispredict_o, 1);
    chk("s_release_redirect", redirect_addr_o, 32'h508);
    tick();
    chk("s_release_miss", miss_cnt_o, 4);
    chk("s_release_empty", empty_o, 1);
    chk("s_release_upd_pc", upd_pc_o, 32'h500);

    // Flush with a simultaneous correct resolution
    idle_in();
    push_in(32'h700, 0, 32'h0);
    tick();
    push_in(32'h704, 0, 32'h0);
    tick();
    push_in(32'h708, 0, 32'h0);
    flush_i = 1;
    res_in(0, 32'h0);
    #1;
    chk("f_mispredict", mispredict_o, 0);
    tick();
    chk("f_hit", hit_cnt_o, 12);
    chk("f_upd_valid", upd_valid_o, 1);
    chk("f_upd_pc", upd_pc_o, 32'h700);
    chk("f_empty", empty_o, 1);
    idle_in();

    // Asynchronous reset mid-traffic
    push_in(32'h900, 1, 32'h940);
    tick();
    push_in(32'h904, 1, 32'h944);
    res_in(1, 32'h940);
    tick();
    chk("r_pre_upd_valid", upd_valid_o, 1);
    chk("r_pre_not_empty", empty_o, 0);
    rst_i = 0;
    #1;
    chk("r_empty", empty_o, 1);
    chk("r_ready", pred_ready_o, 1);
    chk("r_upd_valid", upd_valid_o, 0);
    chk("r_upd_pc", upd_pc_o, 0);
    chk("r_hit", hit_cnt_o, 0);
    chk("r_miss", miss_cnt_o, 0);
    chk("r_proto", proto_err_o, 0);
    idle_in();
    tick();
    rst_i = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
